// File: rtl/perf_counter_streamer.sv
// rtl/perf_counter_streamer.sv - snapshot a performance counter vector and stream it word by word
//
// Purpose:
//   On a trigger in IDLE, all NUM_COUNTERS counter words are copied atomically
//   into a snapshot register. The words are then streamed out one per accepted
//   handshake, in index order 0..NUM_COUNTERS-1. Triggers that arrive while a
//   snapshot is held or streaming are counted in a saturating drop counter.
//
// Optional feature:
//   RSD_PERF_STREAM_PERIODIC_EN - when defined, a free-running interval counter
//   (0..INTERVAL-1) adds an automatic trigger on each wrap, ORed with snapReq.
//   When undefined, no interval counter exists and snapReq is the only trigger.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   perfCounter  in   NUM_COUNTERS*COUNTER_WIDTH counter vector, counter i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   snapReq      in   single-cycle snapshot request
//   outValid     out  outData/outIndex/outLast hold a valid word
//   outReady     in   consumer accepts the word when outValid && outReady
//   outData      out  captured counter value (zero when outValid is low)
//   outIndex     out  index of the counter in outData
//   outLast      out  high with the word for index NUM_COUNTERS-1
//   busy         out  high while a snapshot is held or being streamed
//   dropCount    out  saturating count of triggers rejected while busy

module perf_counter_streamer #(
  parameter int NUM_COUNTERS  = 8,
  parameter int COUNTER_WIDTH = 32,
  parameter int INTERVAL      = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   perfCounter,
  input  logic                                    snapReq,
  output logic                                    outValid,
  input  logic                                    outReady,
  output logic [COUNTER_WIDTH-1:0]                outData,
  output logic [$clog2(NUM_COUNTERS)-1:0]         outIndex,
  output logic                                    outLast,
  output logic                                    busy,
  output logic [7:0]                              dropCount
);

  localparam int IDX_W = $clog2(NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IDX_W-1:0]         index;
  logic [IDX_W-1:0]         index_nxt;
  logic [COUNTER_WIDTH-1:0] snapshot [NUM_COUNTERS];
  logic                     armed;
  logic                     trigger;
  logic                     capture;
  logic                     drop;
  logic                     at_last;

  // The first edge after reset release only arms the block. A release close
  // to that edge must not be able to start a capture, so triggers are gated
  // until armed is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

`ifdef RSD_PERF_STREAM_PERIODIC_EN
  localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(INTERVAL - 1);

  logic [IVL_W-1:0] ivl_cnt;
  logic             ivl_wrap;

  assign ivl_wrap = (ivl_cnt == IVL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ivl_cnt <= '0;
    end else if (ivl_wrap) begin
      ivl_cnt <= '0;
    end else begin
      ivl_cnt <= ivl_cnt + 1'b1;
    end
  end

  // A simultaneous snapReq and wrap collapse into a single trigger.
  assign trigger = armed & (snapReq | ivl_wrap);
`else
  assign trigger = armed & snapReq;
`endif

  assign at_last = (index == LAST_IDX);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          capture   = 1'b1;
          state_nxt = SEND;
          index_nxt = '0;
        end
      end
      SEND: begin
        // Any trigger while streaming is rejected, including on the cycle
        // the last word is accepted.
        drop = trigger;
        if (outReady) begin
          if (at_last) begin
            state_nxt = IDLE;
            index_nxt = '0;
          end else begin
            index_nxt = index + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  // All words are captured on the same edge so the streamed set is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        snapshot[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        snapshot[i] <= perfCounter[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropCount <= 8'd0;
    end else if (drop && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end

  assign busy     = (state == SEND);
  assign outValid = busy;
  assign outIndex = index;
  assign outLast  = busy & at_last;
  assign outData  = busy ? snapshot[index] : '0;

endmodule

// File: tb/tb_perf_counter_streamer.sv
// tb/tb_perf_counter_streamer.sv - scoreboard bench for perf_counter_streamer

module tb_perf_counter_streamer;

  localparam int NC = 8;
  localparam int CW = 32;

  logic               clk;
  logic               rst;
  logic [NC*CW-1:0]   perfCounter;
  logic               snapReq;
  logic               outValid;
  logic               outReady;
  logic [CW-1:0]      outData;
  logic [2:0]         outIndex;
  logic               outLast;
  logic               busy;
  logic [7:0]         dropCount;

  perf_counter_streamer #(
    .NUM_COUNTERS  (NC),
    .COUNTER_WIDTH (CW),
    .INTERVAL      (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .perfCounter (perfCounter),
    .snapReq     (snapReq),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outIndex    (outIndex),
    .outLast     (outLast),
    .busy        (busy),
    .dropCount   (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_perf(input logic [CW-1:0] base);
    for (int i = 0; i < NC; i++) begin
      perfCounter[i*CW +: CW] = base + CW'(i);
    end
  endtask

  // Called at a negedge; the expected words come from the vector the DUT
  // samples on the next rising edge.
  task automatic trigger();
    exp_t e;
    snapReq = 1'b1;
    for (int i = 0; i < NC; i++) begin
      e.data = perfCounter[i*CW +: CW];
      e.idx  = 3'(i);
      e.last = (i == NC - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    snapReq = 1'b0;
  endtask

  // Checks every displayed word against the scoreboard head, optionally
  // stalling on one index and optionally raising snapReq as the last word
  // is accepted.
  task automatic run_stream(input int stall_at, input int stall_len,
                            input bit poke_last, input string tag);
    exp_t e;
    int   waited  = 0;
    int   stalled = 0;
    while (sb.size() > 0 && waited < 200) begin
      e = sb[0];
      check({tag, "_valid"}, 32'(outValid), 32'd1);
      check({tag, "_busy"},  32'(busy),     32'd1);
      check({tag, "_data"},  outData,       e.data);
      check({tag, "_index"}, 32'(outIndex), 32'(e.idx));
      check({tag, "_last"},  32'(outLast),  32'(e.last));
      if (int'(e.idx) == stall_at && stalled < stall_len) begin
        outReady = 1'b0;
        stalled++;
      end else begin
        outReady = 1'b1;
        void'(sb.pop_front());
        if (poke_last && e.last) begin
          snapReq  = 1'b1;
          exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        end
      end
      @(negedge clk);
      waited++;
    end
    snapReq = 1'b0;
    check({tag, "_drained"},  32'(sb.size()),  32'd0);
    check({tag, "_cycles"},   32'(waited),     32'(NC + stall_len));
    check({tag, "_endvalid"}, 32'(outValid),   32'd0);
    check({tag, "_endbusy"},  32'(busy),       32'd0);
    check({tag, "_enddata"},  outData,         32'd0);
    check({tag, "_drop"},     32'(dropCount),  32'(exp_drop));
    sb.delete();
    outReady = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    snapReq     = 1'b0;
    outReady    = 1'b1;
    perfCounter = '0;
    set_perf(32'h100);
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(outValid),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_last",  32'(outLast),   32'd0);
    check("rst_data",  outData,        32'd0);
    check("rst_index", 32'(outIndex),  32'd0);
    check("rst_drop",  32'(dropCount), 32'd0);

    // A request on the first edge after release is ignored.
    rst     = 1'b1;
    snapReq = 1'b1;
    @(negedge clk);
    snapReq = 1'b0;
    check("release_busy",  32'(busy),     32'd0);
    check("release_valid", 32'(outValid), 32'd0);
    @(negedge clk);

    // Basic snapshot, ready held high.
    trigger();
    run_stream(-1, 0, 1'b0, "basic");

    // Input changes after the trigger edge do not reach the stream.
    trigger();
    set_perf(32'hFFFFFFFF);
    for (int i = 0; i < NC; i++) perfCounter[i*CW +: CW] = 32'hFFFFFFFF;
    run_stream(-1, 0, 1'b0, "atomic");
    set_perf(32'h100);

    // Back-pressure on index 3 for 5 cycles.
    trigger();
    run_stream(3, 5, 1'b0, "stall");

    // Trigger on the cycle the last word is accepted is dropped.
    trigger();
    run_stream(-1, 0, 1'b1, "lastdrop");

    // 300 rejected requests saturate the drop counter.
    outReady = 1'b0;
    trigger();
    for (int n = 1; n <= 300; n++) begin
      snapReq = 1'b1;
      @(negedge clk);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      if (n == 200) check("sat_mid", 32'(dropCount), 32'(exp_drop));
    end
    snapReq = 1'b0;
    check("sat_drop",  32'(dropCount), 32'd255);
    check("sat_index", 32'(outIndex),  32'd0);
    check("sat_data",  outData,        32'h100);
    run_stream(-1, 0, 1'b0, "sat_stream");

    // Reset in the middle of a stream.
    trigger();
    sb.delete();
    repeat (4) @(negedge clk);
    check("mid_index", 32'(outIndex), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(outValid),  32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_drop",  32'(dropCount), 32'd0);
    check("abort_data",  outData,        32'd0);
    exp_drop = 0;
    @(negedge clk);
    check("abort_hold", 32'(outValid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wait", 32'(busy), 32'd0);
    trigger();
    run_stream(-1, 0, 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
